// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clock_pkg
// Purpose  : Shared types and constants for the clock setting front-end:
//            RUN/SET state type, field/group encodings and button indices.
// Revision : 1.0  initial release
// ============================================================================
package clock_pkg;

  // Mode state of the setting controller
  typedef enum logic [0:0] {
    RUN = 1'b0,
    SET = 1'b1
  } state_t;

  // Field select within the time group
  localparam logic [1:0] FLD_SEC   = 2'd0;
  localparam logic [1:0] FLD_MIN   = 2'd1;
  localparam logic [1:0] FLD_HOUR  = 2'd2;
  // Field select within the date group (same codes as the time group)
  localparam logic [1:0] FLD_DAY   = 2'd0;
  localparam logic [1:0] FLD_MONTH = 2'd1;
  localparam logic [1:0] FLD_YEAR  = 2'd2;

  // Group select
  localparam logic GRP_TIME = 1'b0;
  localparam logic GRP_DATE = 1'b1;

  // Bit positions of the five buttons inside the internal button vectors
  localparam int unsigned BTN_MODE = 0;
  localparam int unsigned BTN_GRP  = 1;
  localparam int unsigned BTN_NEXT = 2;
  localparam int unsigned BTN_INC  = 3;
  localparam int unsigned BTN_DEC  = 4;
  localparam int unsigned BTN_NUM  = 5;

  // Field advance 0 -> 1 -> 2 -> 0; code 3 is never produced
  function automatic logic [1:0] next_field(input logic [1:0] fld);
    logic [1:0] nxt;
    nxt = FLD_SEC;
    if (fld == FLD_SEC)      nxt = FLD_MIN;
    else if (fld == FLD_MIN) nxt = FLD_HOUR;
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Purpose  : Two-flop synchroniser, stability counter and press pulse for one
//            active-low push-button. The accepted level only moves after
//            DEBOUNCE_CYCLES consecutive synchronised samples that disagree
//            with it. After reset a button must be seen released once before
//            a press can be accepted, so a button held through reset is
//            ignored until it is released and pressed again.
// Revision : 1.0  initial release
// ============================================================================
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             armed_q;
  logic             level_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q;
  logic             differ;

  // A disagreeing sample only counts once the button has been seen released
  assign differ = (sync2_q != level_q) && armed_q;

  // Synchronise the raw pin; flops start "pressed" so a held button never arms
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      armed_q <= armed_q | sync2_q;
    end
  end

  // Count consecutive disagreeing samples; accept the new level on the last one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else if (differ) begin
      if (cnt_q >= CNT_LAST) begin
        level_q <= sync2_q;
        press_q <= ~sync2_q;
        cnt_q   <= '0;
      end else begin
        press_q <= 1'b0;
        cnt_q   <= cnt_q + 1'b1;
      end
    end else begin
      press_q <= 1'b0;
      cnt_q   <= '0;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule
`default_nettype wire

// File: rtl/clock_btn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clock_btn_ctrl
// Purpose  : Setting front-end of the clock. Debounces the five raw buttons,
//            runs the RUN/SET mode machine, selects group and field and drives
//            the active-low inc/dec request levels sampled by the time counter.
//            Optional build macro CLOCK_BTN_TIMEOUT_EN enables the return to
//            RUN after TIMEOUT_CYCLES cycles with every button released.
// Revision : 1.0  initial release
// ============================================================================
module clock_btn_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned TIMEOUT_CYCLES  = 250000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_raw,
  input  logic       grp_raw,
  input  logic       next_raw,
  input  logic       inc_raw,
  input  logic       dec_raw,
  output logic       set_mode,
  output logic       sel,
  output logic [1:0] set_select,
  output logic       inc_btn,
  output logic       dec_btn
);

  logic [BTN_NUM-1:0] raw_vec;
  logic [BTN_NUM-1:0] level_vec;
  logic [BTN_NUM-1:0] press_vec;

  state_t     state_q;
  logic       set_mode_q;
  logic       sel_q;
  logic [1:0] set_select_q;
  logic       inc_btn_q;
  logic       dec_btn_q;

  logic       mode_press;
  logic       grp_press;
  logic       next_press;
  logic       inc_req;
  logic       dec_req;
  logic       any_active;
  logic       timeout;

  assign raw_vec[BTN_MODE] = mode_raw;
  assign raw_vec[BTN_GRP]  = grp_raw;
  assign raw_vec[BTN_NEXT] = next_raw;
  assign raw_vec[BTN_INC]  = inc_raw;
  assign raw_vec[BTN_DEC]  = dec_raw;

  generate
    for (genvar i = 0; i < BTN_NUM; i++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_i  (raw_vec[i]),
        .level_o(level_vec[i]),
        .press_o(press_vec[i])
      );
    end
  endgenerate

  assign mode_press = press_vec[BTN_MODE];
  assign grp_press  = press_vec[BTN_GRP];
  assign next_press = press_vec[BTN_NEXT];

  // A request needs exactly one of inc/dec held; both held cancel each other
  assign inc_req = ~level_vec[BTN_INC] &  level_vec[BTN_DEC];
  assign dec_req =  level_vec[BTN_INC] & ~level_vec[BTN_DEC];

  // Any pressed level or fresh press keeps SET alive
  assign any_active = (~&level_vec) | (|press_vec);

`ifdef CLOCK_BTN_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CYCLES);

  logic [IDLE_W-1:0] idle_q;

  // Count released cycles while in SET; held at zero in RUN so entry starts clean
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= '0;
    end else if ((state_q != SET) || any_active) begin
      idle_q <= '0;
    end else if (idle_q != IDLE_MAX) begin
      idle_q <= idle_q + 1'b1;
    end
  end

  // Current cycle is the last of the idle window: leave on this edge
  assign timeout = (state_q == SET) && !any_active && (idle_q == IDLE_LAST);
`else
  logic unused_timeout;

  assign timeout        = 1'b0;
  assign unused_timeout = any_active ^ (TIMEOUT_CYCLES == 0);
`endif

  // Inc/dec press pulses are not events for the mode machine
  logic unused_press;
  assign unused_press = press_vec[BTN_INC] ^ press_vec[BTN_DEC];

  // Mode machine with registered outputs; mode beats grp, grp beats next
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      set_mode_q   <= 1'b0;
      sel_q        <= GRP_TIME;
      set_select_q <= FLD_SEC;
      inc_btn_q    <= 1'b1;
      dec_btn_q    <= 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          sel_q        <= GRP_TIME;
          set_select_q <= FLD_SEC;
          if (mode_press) begin
            state_q    <= SET;
            set_mode_q <= 1'b1;
            inc_btn_q  <= ~inc_req;
            dec_btn_q  <= ~dec_req;
          end else begin
            set_mode_q <= 1'b0;
            inc_btn_q  <= 1'b1;
            dec_btn_q  <= 1'b1;
          end
        end
        SET: begin
          if (mode_press || timeout) begin
            state_q      <= RUN;
            set_mode_q   <= 1'b0;
            sel_q        <= GRP_TIME;
            set_select_q <= FLD_SEC;
            inc_btn_q    <= 1'b1;
            dec_btn_q    <= 1'b1;
          end else begin
            set_mode_q <= 1'b1;
            if (grp_press) begin
              sel_q        <= ~sel_q;
              set_select_q <= (sel_q == GRP_TIME) ? FLD_DAY : FLD_SEC;
            end else if (next_press) begin
              set_select_q <= next_field(set_select_q);
            end
            inc_btn_q <= ~inc_req;
            dec_btn_q <= ~dec_req;
          end
        end
        default: begin
          state_q      <= RUN;
          set_mode_q   <= 1'b0;
          sel_q        <= GRP_TIME;
          set_select_q <= FLD_SEC;
          inc_btn_q    <= 1'b1;
          dec_btn_q    <= 1'b1;
        end
      endcase
    end
  end

  assign set_mode   = set_mode_q;
  assign sel        = sel_q;
  assign set_select = set_select_q;
  assign inc_btn    = inc_btn_q;
  assign dec_btn    = dec_btn_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_btn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_btn_ctrl
// Purpose  : Self-checking bench for clock_btn_ctrl (DEBOUNCE_CYCLES=4,
//            TIMEOUT_CYCLES=100). Expected behaviour comes from a small
//            abstract model of the mode/group/field rules and from the
//            documented latencies (raw edge -> output change 7 cycles later).
// Revision : 1.0  initial release
// ============================================================================
module tb_clock_btn_ctrl;

  localparam int unsigned D = 4;
  localparam int unsigned T = 100;
  localparam int unsigned LAT = D + 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode_raw = 1'b1;
  logic       grp_raw = 1'b1;
  logic       next_raw = 1'b1;
  logic       inc_raw = 1'b1;
  logic       dec_raw = 1'b1;
  logic       set_mode;
  logic       sel;
  logic [1:0] set_select;
  logic       inc_btn;
  logic       dec_btn;

  int checks = 0;
  int errors = 0;

  // abstract model of the setting interface
  bit m_set = 1'b0;
  bit m_sel = 1'b0;
  int m_fld = 0;

  clock_btn_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode_raw  (mode_raw),
    .grp_raw   (grp_raw),
    .next_raw  (next_raw),
    .inc_raw   (inc_raw),
    .dec_raw   (dec_raw),
    .set_mode  (set_mode),
    .sel       (sel),
    .set_select(set_select),
    .inc_btn   (inc_btn),
    .dec_btn   (dec_btn)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_raw(input int b, input logic v);
    case (b)
      0: mode_raw = v;
      1: grp_raw  = v;
      2: next_raw = v;
      3: inc_raw  = v;
      default: dec_raw = v;
    endcase
  endtask

  // Spec rules for a completed press: mode toggles RUN/SET and clears the
  // selection; group flips the group and restarts at field 0; next steps the
  // field modulo 3. Group/next do nothing in RUN.
  task automatic model_press(input int b);
    case (b)
      0: begin m_set = !m_set; m_sel = 1'b0; m_fld = 0; end
      1: if (m_set) begin m_sel = !m_sel; m_fld = 0; end
      2: if (m_set) m_fld = (m_fld + 1) % 3;
      default: ;
    endcase
  endtask

  task automatic tap(input int b, input int hold);
    set_raw(b, 1'b0);
    cyc(hold);
    set_raw(b, 1'b1);
    cyc(D + 6);
    model_press(b);
  endtask

  task automatic test_reset();
    logic [5:0] got;
    rst_n = 1'b0;
    cyc(3);
    got = {set_mode, sel, set_select, inc_btn, dec_btn};
    checks++; if (got !== 6'b000011) begin errors++; $display("FAIL reset_in: got %b expected %b", got, 6'b000011); end
    rst_n = 1'b1;
    cyc(5);
    got = {set_mode, sel, set_select, inc_btn, dec_btn};
    checks++; if (got !== 6'b000011) begin errors++; $display("FAIL reset_after: got %b expected %b", got, 6'b000011); end
  endtask

  task automatic test_mode_latency();
    set_raw(0, 1'b0);
    cyc(LAT - 1);
    checks++; if (set_mode !== 1'b0) begin errors++; $display("FAIL mode_early: got %b expected 0", set_mode); end
    cyc(1);
    checks++; if (set_mode !== 1'b1) begin errors++; $display("FAIL mode_on_time: got %b expected 1", set_mode); end
    cyc(10 - LAT);
    set_raw(0, 1'b1);
    cyc(12);
    m_set = 1'b1; m_sel = 1'b0; m_fld = 0;
    // short glitch must be filtered
    set_raw(0, 1'b0);
    cyc(D - 1);
    set_raw(0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      checks++; if (set_mode !== 1'b1) begin errors++; $display("FAIL mode_glitch: cycle %0d got %b expected 1", i, set_mode); end
    end
  endtask

  task automatic test_fields_directed();
    logic [1:0] exp_fld [3];
    exp_fld[0] = 2'd1; exp_fld[1] = 2'd2; exp_fld[2] = 2'd0;
    for (int i = 0; i < 3; i++) begin
      tap(2, 6);
      checks++; if (set_select !== exp_fld[i]) begin errors++; $display("FAIL next_step%0d: got %0d expected %0d", i, set_select, exp_fld[i]); end
    end
    tap(2, 6);
    tap(1, 6);
    checks++; if ({sel, set_select} !== 3'b100) begin errors++; $display("FAIL grp_to_date: got sel=%b fld=%0d expected sel=1 fld=0", sel, set_select); end
    tap(2, 6);
    tap(1, 6);
    checks++; if ({sel, set_select} !== 3'b000) begin errors++; $display("FAIL grp_to_time: got sel=%b fld=%0d expected sel=0 fld=0", sel, set_select); end
  endtask

  task automatic test_fields_random();
    logic [5:0] got;
    logic [5:0] exp;
    int r, b, hold;
    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 9);
      b = (r == 0) ? 0 : ((r < 4) ? 1 : 2);
      if ($urandom_range(0, 3) == 0) begin
        set_raw(b, 1'b0);
        cyc($urandom_range(1, D - 1));
        set_raw(b, 1'b1);
        cyc(D + 6);
      end else begin
        hold = $urandom_range(D, D + 8);
        tap(b, hold);
      end
      got = {set_mode, sel, set_select, inc_btn, dec_btn};
      exp = {m_set, m_sel, 2'(m_fld), 2'b11};
      checks++; if (got !== exp) begin errors++; $display("FAIL rand_field%0d: got %b expected %b", i, got, exp); end
    end
    if (!m_set) tap(0, 6);
  endtask

  task automatic test_inc_dec();
    int h;
    set_raw(3, 1'b0);
    cyc(LAT - 1);
    checks++; if (inc_btn !== 1'b1) begin errors++; $display("FAIL inc_early: got %b expected 1", inc_btn); end
    cyc(1);
    checks++; if (inc_btn !== 1'b0) begin errors++; $display("FAIL inc_on_time: got %b expected 0", inc_btn); end
    for (int i = 0; i < 50 - int'(LAT); i++) begin
      cyc(1);
      checks++; if ({inc_btn, dec_btn} !== 2'b01) begin errors++; $display("FAIL inc_hold: cycle %0d got %b expected 01", i, {inc_btn, dec_btn}); end
    end
    set_raw(3, 1'b1);
    cyc(LAT - 1);
    checks++; if (inc_btn !== 1'b0) begin errors++; $display("FAIL inc_rel_early: got %b expected 0", inc_btn); end
    cyc(1);
    checks++; if (inc_btn !== 1'b1) begin errors++; $display("FAIL inc_rel: got %b expected 1", inc_btn); end
    // both held: no request at all
    set_raw(3, 1'b0);
    set_raw(4, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      checks++; if ({inc_btn, dec_btn} !== 2'b11) begin errors++; $display("FAIL both_held: cycle %0d got %b expected 11", i, {inc_btn, dec_btn}); end
    end
    set_raw(3, 1'b1);
    set_raw(4, 1'b1);
    cyc(10);
    // dec alone with random hold
    h = $urandom_range(10, 30);
    set_raw(4, 1'b0);
    cyc(LAT);
    checks++; if ({inc_btn, dec_btn} !== 2'b10) begin errors++; $display("FAIL dec_on: got %b expected 10", {inc_btn, dec_btn}); end
    cyc(h - int'(LAT));
    set_raw(4, 1'b1);
    cyc(LAT);
    checks++; if (dec_btn !== 1'b1) begin errors++; $display("FAIL dec_rel: got %b expected 1", dec_btn); end
    cyc(5);
  endtask

  task automatic test_timeout();
    logic [5:0] got;
    logic [5:0] exp;
    set_raw(2, 1'b0);
    cyc(6);
    set_raw(2, 1'b1);
    model_press(2);
    // debounced release lands D+2 edges later; the idle window then runs T cycles
`ifdef CLOCK_BTN_TIMEOUT_EN
    cyc(D + 2 + T - 1);
    checks++; if (set_mode !== 1'b1) begin errors++; $display("FAIL timeout_early: got %b expected 1", set_mode); end
    cyc(1);
    m_set = 1'b0; m_sel = 1'b0; m_fld = 0;
    got = {set_mode, sel, set_select, inc_btn, dec_btn};
    exp = {m_set, m_sel, 2'(m_fld), 2'b11};
    checks++; if (got !== exp) begin errors++; $display("FAIL timeout_exit: got %b expected %b", got, exp); end
`else
    cyc(1000);
    got = {set_mode, sel, set_select, inc_btn, dec_btn};
    exp = {m_set, m_sel, 2'(m_fld), 2'b11};
    checks++; if (got !== exp) begin errors++; $display("FAIL no_timeout: got %b expected %b", got, exp); end
    tap(0, 6);
`endif
    // inc held in RUN never requests
    set_raw(3, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      checks++; if (inc_btn !== 1'b1) begin errors++; $display("FAIL inc_in_run: cycle %0d got %b expected 1", i, inc_btn); end
    end
    set_raw(3, 1'b1);
    cyc(10);
  endtask

  task automatic test_reset_mid();
    logic [5:0] got;
    logic [5:0] exp;
    tap(0, 6);
    tap(1, 6);
    tap(2, 6);
    tap(2, 6);
    got = {set_mode, sel, set_select, inc_btn, dec_btn};
    exp = {m_set, m_sel, 2'(m_fld), 2'b11};
    checks++; if (got !== 6'b111011 || got !== exp) begin errors++; $display("FAIL pre_reset_state: got %b expected %b", got, exp); end
    set_raw(3, 1'b0);
    cyc(8);
    checks++; if (inc_btn !== 1'b0) begin errors++; $display("FAIL pre_reset_inc: got %b expected 0", inc_btn); end
    #3;
    rst_n = 1'b0;
    #1;
    got = {set_mode, sel, set_select, inc_btn, dec_btn};
    checks++; if (got !== 6'b000011) begin errors++; $display("FAIL async_reset: got %b expected %b", got, 6'b000011); end
    m_set = 1'b0; m_sel = 1'b0; m_fld = 0;
    cyc(3);
    rst_n = 1'b1;
    cyc(20);
    tap(0, 6);
    got = {set_mode, sel, set_select, inc_btn, dec_btn};
    exp = {m_set, m_sel, 2'(m_fld), 2'b11};
    checks++; if (got !== exp) begin errors++; $display("FAIL held_through_reset: got %b expected %b", got, exp); end
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      checks++; if (inc_btn !== 1'b1) begin errors++; $display("FAIL held_inc_ignored: cycle %0d got %b expected 1", i, inc_btn); end
    end
    set_raw(3, 1'b1);
    cyc(10);
    set_raw(3, 1'b0);
    cyc(LAT);
    checks++; if (inc_btn !== 1'b0) begin errors++; $display("FAIL inc_repress: got %b expected 0", inc_btn); end
    set_raw(3, 1'b1);
    cyc(10);
  endtask

  initial begin
    test_reset();
    test_mode_latency();
    test_fields_directed();
    test_fields_random();
    test_inc_dec();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
